multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready handshakes to instruction and data memory.
- Optionally supports M-extension ops that stall on a multi-cycle ALU.
- Sits between the instruction register and the datapath; drives the datapath controls plus PC/IR write enables and memory requests.

Parameters:
- ENABLE_M, 1, 1 = decode opcode 0110011 with Funct7=0000001 as mul/div and handshake with the ALU; 0 = treat it as illegal.
- ENABLE_AUIPC, 1, 1 = decode 0010111; 0 = illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  from IR; stable from DECODE until the next FETCH
- Funct3  in  3  from IR
- Funct7  in  7  from IR
- im_ready  in  1  instruction memory data valid
- dm_ready  in  1  data memory access complete
- alu_done  in  1  multi-cycle ALU result valid
- IMReq  out  1  instruction fetch request
- IRWr  out  1  latch instruction register
- PCWr  out  1  update PC (PC+4 or branch unit target)
- DMReq  out  1  data memory request
- alu_start  out  1  one-cycle start pulse to the multi-cycle ALU
- RUWr  out  1  register file write
- ALUOp  out  5  {m_op, Funct7[5], Funct3}
- ImmSrc  out  3  immediate format
- ALUASrc  out  1  0 = rs1, 1 = PC
- ALUBSrc  out  1  0 = rs2, 1 = imm
- DMWr  out  1  store
- DMCtrl  out  3  access size/sign (Funct3)
- BrOp  out  5  branch-unit control
- RUDataWrSrc  out  2  00 = ALU, 01 = DM, 10 = PC+4
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- state_o  out  3  current state, for debug

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset:
  - State = FETCH.
  - Decode class register = NONE.
  - All outputs 0, except IMReq = 1 in the first cycle after reset deasserts.
- States and transitions:
  - FETCH: IMReq = 1. On im_ready, pulse IRWr = 1 and go to DECODE. Otherwise hold.
  - DECODE (1 cycle): classify opcode into R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MUL or ILLEGAL. Register the class. Go to EXEC, or TRAP if ILLEGAL.
  - EXEC:
    - ALU-class instructions drive ALU controls.
    - MUL: alu_start pulses in the first EXEC cycle only, then stays in EXEC until alu_done.
    - LOAD/STORE go to MEM.
    - BRANCH, JAL and JALR assert BrOp and PCWr this cycle. JAL/JALR then go to WB; BRANCH goes to FETCH.
    - All other classes go to WB.
  - MEM: DMReq = 1, DMWr = 1 for STORE, DMCtrl = Funct3. Hold until dm_ready. Then STORE goes to FETCH with PCWr = 1; LOAD goes to WB.
  - WB: RUWr = 1 for one cycle. PCWr = 1 unless already asserted for a jump. Go to FETCH.
  - TRAP: illegal_instr = 1 for one cycle, all write enables 0, go to FETCH. PC is not advanced (trap handling is external).
- Datapath encodings, held valid through EXEC/MEM/WB:
  - R: ALUOp = {0, F7[5], F3}, ALUBSrc = 0.
  - I: ALUOp = {0, F7[5], F3} for F3 = 001/101, else {0, 0, F3}; ImmSrc = 000, ALUBSrc = 1.
  - LOAD: ALUOp = 0, ImmSrc = 000, RUDataWrSrc = 01.
  - STORE: ImmSrc = 001.
  - BRANCH: ImmSrc = 101, BrOp = {01, F3}, ALUASrc = 1.
  - JAL: ImmSrc = 110, BrOp = 10000, ALUASrc = 1, RUDataWrSrc = 10.
  - JALR: ImmSrc = 000, BrOp = 10000, RUDataWrSrc = 10.
  - LUI: ImmSrc = 010, ALUOp = 00111.
  - AUIPC: ImmSrc = 010, ALUASrc = 1, ALUOp = 0.
  - MUL: ALUOp = {1, 0, F3}.
- Outside active states, datapath controls are 0. RUWr, DMWr, PCWr and IRWr are never high in FETCH/DECODE except IRWr as described above.
- Latency with zero-wait memories (im_ready/dm_ready high on first request):
  - R/I/LUI/AUIPC: 4 cycles.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
  - JAL/JALR: 4.
  - MUL: 4 + ALU wait cycles.
- Boundaries:
  - im_ready, dm_ready or alu_done asserted outside its waiting state is ignored.
  - alu_done in the same cycle as alu_start completes EXEC in that cycle.
  - rst mid-instruction aborts immediately; no write enable may assert in the reset cycle.

Decomposition:
- Package cu_pkg holds:
  - state enum.
  - instruction class enum.
  - opcode constants.
  - ImmSrc, BrOp and RUDataWrSrc encodings.
- One sub-module, cu_decode: combinational opcode/Funct to class and static control fields. The FSM stays in the top module.

Test Plan:
- rst held 2 cycles, im_ready = 1, ADD (opcode 0110011, F3 = 000, F7 = 0000000) -> FETCH, DECODE, EXEC, WB. RUWr = 1 only in cycle 4. ALUOp = 00000.
- LW (0000011, F3 = 010), dm_ready delayed 3 cycles -> DMReq high for 4 cycles, DMCtrl = 010, RUDataWrSrc = 01, RUWr in the following cycle.
- BEQ (1100011, F3 = 000) -> BrOp = 01000, ImmSrc = 101, PCWr in EXEC, back to FETCH after 3 cycles, RUWr never high.
- MUL (0110011, F7 = 0000001), alu_done after 5 cycles -> single alu_start pulse, ALUOp = 10000, RUWr 1 cycle after alu_done. With ENABLE_M = 0 -> illegal_instr pulse instead.
- Opcode 1111111 -> illegal_instr for exactly 1 cycle, no PCWr/RUWr/DMWr, next state FETCH.
- SW with rst asserted during MEM -> DMWr = 0 in the reset cycle, state FETCH, all outputs at reset values.

Source files
------------

// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_pkg
// Description : Shared types and encodings for the multi-cycle RV32I control
//               unit: FSM states, instruction classes, opcodes and the
//               datapath control field encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

   // FSM states; the encoding is also exported on state_o for debug
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   // Instruction class captured in DECODE and held until the next DECODE
   typedef enum logic [3:0] {
      CLS_NONE    = 4'd0,
      CLS_R       = 4'd1,
      CLS_I       = 4'd2,
      CLS_LOAD    = 4'd3,
      CLS_STORE   = 4'd4,
      CLS_BRANCH  = 4'd5,
      CLS_JAL     = 4'd6,
      CLS_JALR    = 4'd7,
      CLS_LUI     = 4'd8,
      CLS_AUIPC   = 4'd9,
      CLS_MUL     = 4'd10,
      CLS_ILLEGAL = 4'd11
   } instr_class_t;

   // RV32I major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Funct7 values accepted on the register-register opcode
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // Immediate generator formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_U = 3'b010;
   localparam logic [2:0] IMM_B = 3'b101;
   localparam logic [2:0] IMM_J = 3'b110;

   // Branch unit controls: conditional branches carry Funct3 in the low bits
   localparam logic [4:0] BROP_NONE     = 5'b00000;
   localparam logic [4:0] BROP_JUMP     = 5'b10000;
   localparam logic [1:0] BROP_COND_PFX = 2'b01;

   // Register file write-back source select
   localparam logic [1:0] WRSRC_ALU = 2'b00;
   localparam logic [1:0] WRSRC_DM  = 2'b01;
   localparam logic [1:0] WRSRC_PC4 = 2'b10;

   // ALU operation used by LUI to pass the immediate straight through
   localparam logic [4:0] ALUOP_PASS_B = 5'b00111;

   // Static datapath fields produced by the decoder for one instruction
   typedef struct packed {
      logic [4:0] alu_op;
      logic [2:0] imm_src;
      logic       alu_a_src;
      logic       alu_b_src;
      logic [4:0] br_op;
      logic [1:0] ru_data_wr_src;
      logic [2:0] dm_ctrl;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Bundle of instruction-register fields, memory/ALU handshakes
//               and datapath controls between the control unit (master) and
//               the datapath/memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;

   // Instruction register fields
   logic [6:0] opcode;
   logic [2:0] Funct3;
   logic [6:0] Funct7;

   // Handshakes from memories and the multi-cycle ALU
   logic       im_ready;
   logic       dm_ready;
   logic       alu_done;

   // Sequencing and memory requests
   logic       IMReq;
   logic       IRWr;
   logic       PCWr;
   logic       DMReq;
   logic       alu_start;
   logic       RUWr;

   // Datapath controls
   logic [4:0] ALUOp;
   logic [2:0] ImmSrc;
   logic       ALUASrc;
   logic       ALUBSrc;
   logic       DMWr;
   logic [2:0] DMCtrl;
   logic [4:0] BrOp;
   logic [1:0] RUDataWrSrc;

   // Status
   logic       illegal_instr;
   logic [2:0] state_o;

   modport master (
      input  opcode, Funct3, Funct7, im_ready, dm_ready, alu_done,
      output IMReq, IRWr, PCWr, DMReq, alu_start, RUWr,
      output ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMWr, DMCtrl, BrOp, RUDataWrSrc,
      output illegal_instr, state_o
   );

   modport slave (
      output opcode, Funct3, Funct7, im_ready, dm_ready, alu_done,
      input  IMReq, IRWr, PCWr, DMReq, alu_start, RUWr,
      input  ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMWr, DMCtrl, BrOp, RUDataWrSrc,
      input  illegal_instr, state_o
   );

endinterface
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ============================================================================
// Module      : cu_decode
// Description : Combinational classifier mapping opcode/Funct3/Funct7 to an
//               instruction class and the static datapath control fields.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_decode
   import cu_pkg::*;
#(
   parameter bit ENABLE_M     = 1'b1,
   parameter bit ENABLE_AUIPC = 1'b1
) (
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic [6:0]   funct7,
   output instr_class_t cls,
   output ctrl_t        ctrl
);

   // Anything not explicitly recognised falls through as ILLEGAL with all
   // controls cleared. The ALU B operand selects the immediate for every
   // class whose ALU operation consumes one (address or target generation).
   always_comb begin
      cls  = CLS_ILLEGAL;
      ctrl = CTRL_NONE;
      case (opcode)
         OPC_OP: begin
            if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) begin
               cls          = CLS_R;
               ctrl.alu_op  = {1'b0, funct7[5], funct3};
            end else if ((funct7 == F7_MULDIV) && ENABLE_M) begin
               cls          = CLS_MUL;
               ctrl.alu_op  = {2'b10, funct3};
            end
         end
         OPC_OP_IMM: begin
            cls            = CLS_I;
            ctrl.imm_src   = IMM_I;
            ctrl.alu_b_src = 1'b1;
            // Only the shifts use Funct7[5]; elsewhere those bits are imm
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
               ctrl.alu_op = {1'b0, funct7[5], funct3};
            end else begin
               ctrl.alu_op = {2'b00, funct3};
            end
         end
         OPC_LOAD: begin
            cls                 = CLS_LOAD;
            ctrl.imm_src        = IMM_I;
            ctrl.alu_b_src      = 1'b1;
            ctrl.ru_data_wr_src = WRSRC_DM;
            ctrl.dm_ctrl        = funct3;
         end
         OPC_STORE: begin
            cls            = CLS_STORE;
            ctrl.imm_src   = IMM_S;
            ctrl.alu_b_src = 1'b1;
            ctrl.dm_ctrl   = funct3;
         end
         OPC_BRANCH: begin
            cls            = CLS_BRANCH;
            ctrl.imm_src   = IMM_B;
            ctrl.alu_a_src = 1'b1;
            ctrl.alu_b_src = 1'b1;
            ctrl.br_op     = {BROP_COND_PFX, funct3};
         end
         OPC_JAL: begin
            cls                 = CLS_JAL;
            ctrl.imm_src        = IMM_J;
            ctrl.alu_a_src      = 1'b1;
            ctrl.alu_b_src      = 1'b1;
            ctrl.br_op          = BROP_JUMP;
            ctrl.ru_data_wr_src = WRSRC_PC4;
         end
         OPC_JALR: begin
            cls                 = CLS_JALR;
            ctrl.imm_src        = IMM_I;
            ctrl.alu_b_src      = 1'b1;
            ctrl.br_op          = BROP_JUMP;
            ctrl.ru_data_wr_src = WRSRC_PC4;
         end
         OPC_LUI: begin
            cls            = CLS_LUI;
            ctrl.imm_src   = IMM_U;
            ctrl.alu_b_src = 1'b1;
            ctrl.alu_op    = ALUOP_PASS_B;
         end
         OPC_AUIPC: begin
            if (ENABLE_AUIPC) begin
               cls            = CLS_AUIPC;
               ctrl.imm_src   = IMM_U;
               ctrl.alu_a_src = 1'b1;
               ctrl.alu_b_src = 1'b1;
            end
         end
         default: begin
            cls  = CLS_ILLEGAL;
            ctrl = CTRL_NONE;
         end
      endcase
      if (cls == CLS_ILLEGAL) begin
         ctrl.br_op = BROP_NONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle RV32I control unit. Sequences each instruction
//               through FETCH/DECODE/EXEC/MEM/WB with ready handshakes to the
//               memories and an optional multi-cycle M-extension ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter bit ENABLE_M     = 1'b1,
   parameter bit ENABLE_AUIPC = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst,
   multicycle_control_unit_if.master         bus
);

   state_t       r_state;
   state_t       w_state_next;
   instr_class_t w_dec_class;
   ctrl_t        w_dec_ctrl;
   instr_class_t r_class;
   ctrl_t        r_ctrl;
   logic         r_alu_started;
   logic         w_is_jump;
   logic         w_dp_active;

   cu_decode #(
      .ENABLE_M     (ENABLE_M),
      .ENABLE_AUIPC (ENABLE_AUIPC)
   ) u_decode (
      .opcode (bus.opcode),
      .funct3 (bus.Funct3),
      .funct7 (bus.Funct7),
      .cls    (w_dec_class),
      .ctrl   (w_dec_ctrl)
   );

   assign w_is_jump   = (r_class == CLS_JAL) || (r_class == CLS_JALR);
   assign w_dp_active = (r_state == ST_EXEC) || (r_state == ST_MEM) ||
                        (r_state == ST_WB);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Capture the decoded class/controls in DECODE; remember that the ALU has
   // been started while a MUL waits in EXEC so the start pulse is single.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_class       <= CLS_NONE;
         r_ctrl        <= CTRL_NONE;
         r_alu_started <= 1'b0;
      end else begin
         if (r_state == ST_DECODE) begin
            r_class <= w_dec_class;
            r_ctrl  <= w_dec_ctrl;
         end
         r_alu_started <= (r_state == ST_EXEC) && (w_state_next == ST_EXEC);
      end
   end

   // Next-state logic; each handshake is only looked at in its waiting state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (bus.im_ready) begin
               w_state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            w_state_next = (w_dec_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
         end
         ST_EXEC: begin
            case (r_class)
               CLS_MUL:              w_state_next = bus.alu_done ? ST_WB : ST_EXEC;
               CLS_LOAD, CLS_STORE:  w_state_next = ST_MEM;
               CLS_BRANCH:           w_state_next = ST_FETCH;
               default:              w_state_next = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (bus.dm_ready) begin
               w_state_next = (r_class == CLS_STORE) ? ST_FETCH : ST_WB;
            end
         end
         ST_WB:   w_state_next = ST_FETCH;
         ST_TRAP: w_state_next = ST_FETCH;
         default: w_state_next = ST_FETCH;
      endcase
   end

   // Output decode; everything is forced low while rst is high so an aborted
   // instruction cannot write anything in the reset cycle.
   always_comb begin
      bus.IMReq         = 1'b0;
      bus.IRWr          = 1'b0;
      bus.PCWr          = 1'b0;
      bus.DMReq         = 1'b0;
      bus.alu_start     = 1'b0;
      bus.RUWr          = 1'b0;
      bus.DMWr          = 1'b0;
      bus.DMCtrl        = 3'b000;
      bus.illegal_instr = 1'b0;
      bus.ALUOp         = 5'b00000;
      bus.ImmSrc        = 3'b000;
      bus.ALUASrc       = 1'b0;
      bus.ALUBSrc       = 1'b0;
      bus.BrOp          = 5'b00000;
      bus.RUDataWrSrc   = 2'b00;
      bus.state_o       = rst ? ST_FETCH : r_state;
      if (!rst) begin
         if (w_dp_active) begin
            bus.ALUOp       = r_ctrl.alu_op;
            bus.ImmSrc      = r_ctrl.imm_src;
            bus.ALUASrc     = r_ctrl.alu_a_src;
            bus.ALUBSrc     = r_ctrl.alu_b_src;
            bus.BrOp        = r_ctrl.br_op;
            bus.RUDataWrSrc = r_ctrl.ru_data_wr_src;
         end
         case (r_state)
            ST_FETCH: begin
               bus.IMReq = 1'b1;
               bus.IRWr  = bus.im_ready;
            end
            ST_EXEC: begin
               if (r_class == CLS_MUL) begin
                  bus.alu_start = !r_alu_started;
               end
               if ((r_class == CLS_BRANCH) || w_is_jump) begin
                  bus.PCWr = 1'b1;
               end
            end
            ST_MEM: begin
               bus.DMReq  = 1'b1;
               bus.DMWr   = (r_class == CLS_STORE);
               bus.DMCtrl = r_ctrl.dm_ctrl;
               bus.PCWr   = bus.dm_ready && (r_class == CLS_STORE);
            end
            ST_WB: begin
               bus.RUWr = 1'b1;
               bus.PCWr = !w_is_jump;
            end
            ST_TRAP: begin
               bus.illegal_instr = 1'b1;
            end
            default: begin
               bus.IMReq = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
